// File: rtl/freq_meter.sv
// Gated frequency meter. Counts synchronized rising edges of sig_in over a fixed
// window of GATE_CYCLES reference clocks and publishes the count with a strobe.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int COUNT_W     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sig_in,
  input  logic               start,
  input  logic               continuous,
  output logic               busy,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_valid,
  output logic               overflow
);

  localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   rise;

  logic [0:0]         state_reg;
  logic [GATE_W-1:0]  gate_reg;
  logic [COUNT_W-1:0] edge_reg;
  logic               sticky_reg;

  logic [COUNT_W-1:0] edge_next;
  logic               sticky_next;
  logic               edge_max;

  // The synchronizer and edge detector run in every state so the first
  // cycle of a window already sees a settled history.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign edge_max = &edge_reg;

  always_comb begin
    edge_next   = edge_reg;
    sticky_next = sticky_reg;
    if (rise) begin
      if (edge_max) begin
        sticky_next = 1'b1;
      end else begin
        edge_next = edge_reg + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      gate_reg    <= '0;
      edge_reg    <= '0;
      sticky_reg  <= 1'b0;
      count_out   <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg  <= ST_MEASURE;
            gate_reg   <= '0;
            edge_reg   <= '0;
            sticky_reg <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (gate_reg == GATE_LAST) begin
            // A rise in the last gate cycle is folded into the published result.
            count_out   <= edge_next;
            overflow    <= sticky_next;
            count_valid <= 1'b1;
            gate_reg    <= '0;
            edge_reg    <= '0;
            sticky_reg  <= 1'b0;
            if (!continuous) begin
              state_reg <= ST_IDLE;
            end
          end else begin
            gate_reg   <= gate_reg + GATE_W'(1);
            edge_reg   <= edge_next;
            sticky_reg <= sticky_next;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_reg == ST_MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: an 8-bit and a 4-bit instance share stimulus and are
// compared every cycle against a window-sum reference model.
module tb_freq_meter;

  localparam int G = 100;
  localparam int S = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sig_in = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;

  logic       busy0, valid0, ovf0;
  logic [7:0] count0;
  logic       busy1, valid1, ovf1;
  logic [3:0] count1;

  always #5 clock = ~clock;

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(8), .SYNC_STAGES(S)) dut0 (
    .clock(clock), .reset(reset), .sig_in(sig_in), .start(start),
    .continuous(continuous), .busy(busy0), .count_out(count0),
    .count_valid(valid0), .overflow(ovf0)
  );

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(4), .SYNC_STAGES(S)) dut1 (
    .clock(clock), .reset(reset), .sig_in(sig_in), .start(start),
    .continuous(continuous), .busy(busy1), .count_out(count1),
    .count_valid(valid1), .overflow(ovf1)
  );

  int vectors = 0;
  int miscompares = 0;
  int nvalid0 = 0;
  bit check_en = 1'b0;

  // Stimulus source: 0 hold low, 1 hold high, 2 square wave, 3 random widths >= 2.
  int sig_mode = 0;
  int sig_half = 5;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clock);
      case (sig_mode)
        0: sig_in = 1'b0;
        1: sig_in = 1'b1;
        2: begin
          if (ph <= 0) begin
            sig_in = ~sig_in;
            ph = sig_half - 1;
          end else ph--;
        end
        default: begin
          if (ph <= 0) begin
            sig_in = ~sig_in;
            ph = $urandom_range(1, 5);
          end else ph--;
        end
      endcase
    end
  end

  // Reference model: a rise is a 0->1 step in the sampled input seen S cycles late;
  // each window sums its rises and the result is clipped to the counter range.
  bit hist [0:S];
  bit m_meas [2];
  int m_gate [2];
  int m_rises [2];
  int m_out [2];
  bit m_ov [2];
  bit m_valid [2];
  int maxv [2] = '{255, 15};

  initial begin
    for (int i = 0; i <= S; i++) hist[i] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_meas[k] = 0; m_gate[k] = 0; m_rises[k] = 0;
      m_out[k] = 0; m_ov[k] = 0; m_valid[k] = 0;
    end
    forever begin
      bit r;
      @(posedge clock);
      if (reset) begin
        check_en = 1'b1;
        for (int i = 0; i <= S; i++) hist[i] = 1'b0;
        for (int k = 0; k < 2; k++) begin
          m_meas[k] = 0; m_gate[k] = 0; m_rises[k] = 0;
          m_out[k] = 0; m_ov[k] = 0; m_valid[k] = 0;
        end
      end else begin
        r = hist[S-1] & ~hist[S];
        for (int i = S; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sig_in;
        for (int k = 0; k < 2; k++) begin
          m_valid[k] = 0;
          if (m_meas[k]) begin
            m_rises[k] += int'(r);
            if (m_gate[k] == G - 1) begin
              m_out[k] = (m_rises[k] > maxv[k]) ? maxv[k] : m_rises[k];
              m_ov[k] = (m_rises[k] > maxv[k]);
              m_valid[k] = 1;
              m_gate[k] = 0;
              m_rises[k] = 0;
              if (!continuous) m_meas[k] = 0;
            end else begin
              m_gate[k]++;
            end
          end else if (start) begin
            m_meas[k] = 1;
            m_gate[k] = 0;
            m_rises[k] = 0;
          end
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (check_en) begin
        vectors++;
        if (busy0 !== m_meas[0] || valid0 !== m_valid[0] || ovf0 !== m_ov[0] ||
            int'(count0) != m_out[0] || $isunknown(count0)) begin
          miscompares++;
          $display("FAIL model8 t=%0t busy=%b valid=%b count=%0d ovf=%b required busy=%b valid=%b count=%0d ovf=%b",
                   $time, busy0, valid0, count0, ovf0, m_meas[0], m_valid[0], m_out[0], m_ov[0]);
        end
        vectors++;
        if (busy1 !== m_meas[1] || valid1 !== m_valid[1] || ovf1 !== m_ov[1] ||
            int'(count1) != m_out[1] || $isunknown(count1)) begin
          miscompares++;
          $display("FAIL model4 t=%0t busy=%b valid=%b count=%0d ovf=%b required busy=%b valid=%b count=%0d ovf=%b",
                   $time, busy1, valid1, count1, ovf1, m_meas[1], m_valid[1], m_out[1], m_ov[1]);
        end
        if (valid0 === 1'b1) nvalid0++;
      end
    end
  end

  task automatic chk(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
    $display("check %s actual=%0d required=%0d", name, actual, required);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Pulse start so it is sampled at exactly one posedge; returns after that posedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (valid0 !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (valid0 !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout actual=no_valid required=valid", name);
    end
  endtask

  initial begin
    int nv;
    cycles(2);
    reset = 1'b0;
    chk("reset_busy", int'(busy0), 0);
    chk("reset_count", int'(count0), 0);

    // Single window, period 10.
    sig_mode = 2; sig_half = 5;
    cycles(10);
    pulse_start();
    chk("single_busy_t1", int'(busy0), 1);
    cycles(99);
    chk("single_busy_t100", int'(busy0), 1);
    chk("single_novalid_t100", int'(valid0), 0);
    cycles(1);
    chk("single_valid_t101", int'(valid0), 1);
    chk("single_count8", int'(count0), 10);
    chk("single_ovf8", int'(ovf0), 0);
    chk("single_count4", int'(count1), 10);
    chk("single_idle", int'(busy0), 0);
    cycles(1);
    chk("single_valid_pulse", int'(valid0), 0);
    chk("single_hold", int'(count0), 10);

    // No activity: held low, then held high.
    sig_mode = 0;
    cycles(10);
    pulse_start();
    cycles(100);
    chk("low_valid", int'(valid0), 1);
    chk("low_count", int'(count0), 0);
    sig_mode = 1;
    cycles(10);
    pulse_start();
    cycles(100);
    chk("high_valid", int'(valid0), 1);
    chk("high_count", int'(count0), 0);
    chk("high_ovf", int'(ovf0), 0);

    // Saturation in the 4-bit instance, then recovery.
    sig_mode = 2; sig_half = 2;
    cycles(10);
    pulse_start();
    cycles(100);
    chk("sat_count8", int'(count0), 25);
    chk("sat_count4", int'(count1), 15);
    chk("sat_ovf4", int'(ovf1), 1);
    sig_half = 5;
    cycles(10);
    pulse_start();
    cycles(100);
    chk("resat_count4", int'(count1), 10);
    chk("resat_ovf4", int'(ovf1), 0);

    // Continuous windows at period 20.
    sig_half = 10;
    continuous = 1'b1;
    cycles(20);
    pulse_start();
    for (int w = 0; w < 3; w++) begin
      wait_valid("cont_wait");
      chk("cont_count", int'(count0), 5);
      chk("cont_busy", int'(busy0), 1);
      cycles(1);
    end
    cycles(50);
    continuous = 1'b0;
    wait_valid("cont_last_wait");
    chk("cont_last_count", int'(count0), 5);
    chk("cont_last_busy", int'(busy0), 0);
    cycles(1);

    // Reset in the middle of a window.
    sig_half = 5;
    cycles(10);
    pulse_start();
    cycles(49);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_count", int'(count0), 0);
    chk("rst_valid", int'(valid0), 0);
    chk("rst_ovf", int'(ovf0), 0);
    nv = nvalid0;
    cycles(70);
    chk("rst_no_valid", nvalid0 - nv, 0);
    pulse_start();
    cycles(100);
    chk("rst_fresh_count", int'(count0), 10);

    // Start while busy is ignored.
    cycles(10);
    nv = nvalid0;
    pulse_start();
    cycles(39);
    pulse_start();
    cycles(60);
    chk("sbusy_valid_t101", int'(valid0), 1);
    chk("sbusy_count", int'(count0), 10);
    chk("sbusy_idle", int'(busy0), 0);
    cycles(120);
    chk("sbusy_one_valid", nvalid0 - nv, 1);

    // Randomized operation against the model.
    sig_mode = 3;
    for (int i = 0; i < 5000; i++) begin
      start = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 199) == 0) continuous = ~continuous;
      reset = ($urandom_range(0, 1499) == 0);
      @(negedge clock);
    end
    start = 1'b0;
    reset = 1'b0;
    continuous = 1'b0;
    cycles(250);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
